// File: rtl/alu_requester_if.sv
// rtl/alu_requester_if.sv - handshake bundle between command source, alu_requester, ALU and response sink
//
// Signal groups:
//   cmd_*   : command stream into the requester (valid/ready, 8-bit x/y, 3-bit op)
//   alu_*   : ALU side (operands, op, begin pulse out; end level and 16-bit result in)
//   rsp_*   : response stream out (valid/ready, 16-bit data, op, timeout flag)
//   busy    : requester has queued or in-flight work
// Modports: slave = the requester itself, master = everything around it.
interface alu_requester_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_x;
  logic [7:0]  cmd_y;
  logic [2:0]  cmd_op;
  logic [7:0]  alu_x;
  logic [7:0]  alu_y;
  logic [2:0]  alu_op;
  logic        alu_begin;
  logic        alu_end;
  logic [15:0] alu_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_op;
  logic        rsp_timeout;
  logic        busy;

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_op, alu_end, alu_out, rsp_ready,
    output cmd_ready, alu_x, alu_y, alu_op, alu_begin,
           rsp_valid, rsp_data, rsp_op, rsp_timeout, busy
  );

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_op, alu_end, alu_out, rsp_ready,
    input  cmd_ready, alu_x, alu_y, alu_op, alu_begin,
           rsp_valid, rsp_data, rsp_op, rsp_timeout, busy
  );
endinterface

// File: rtl/alu_requester.sv
// rtl/alu_requester.sv - queues ALU commands, issues them one at a time and returns results or timeouts
//
// Ports:
//   clk   : single clock, all state updates on the rising edge
//   reset : synchronous active-high reset
//   bus   : alu_requester_if.slave (command stream, ALU handshake, response stream, busy)
// Parameters:
//   DEPTH   : command FIFO entries (power of two, 2..16)
//   TIMEOUT : WAIT cycles allowed before a command is reported as timed out
module alu_requester #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input logic          clk,
  input logic          reset,
  alu_requester_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, RECOVER} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [18:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] tcnt;
  logic          end_prev;
  logic          push;
  logic          pop;
  logic          done;
  logic          expired;
  logic          rsp_fire;

  assign bus.cmd_ready = (count != CW'(DEPTH));
  assign bus.alu_begin = (state == ISSUE);
  assign bus.busy      = (state != IDLE) || (count != '0);

  assign push     = bus.cmd_valid && bus.cmd_ready;
  assign pop      = (state == IDLE) && (count != '0) && !bus.rsp_valid;
  // Only a rising edge of alu_end counts; end_prev is primed in ISSUE so a
  // level left over from the previous command is ignored.
  assign done     = (state == WAIT) && bus.alu_end && !end_prev;
  assign expired  = (state == WAIT) && (tcnt == TW'(TIMEOUT - 1));
  assign rsp_fire = bus.rsp_valid && bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT: begin
        if (done)         state_nxt = RESP;
        else if (expired) state_nxt = RECOVER;
      end
      RESP:    if (rsp_fire) state_nxt = IDLE;
      // The timeout response is already visible here; if the consumer takes
      // it while we wait for alu_end to drop, go straight back to IDLE so the
      // same response is not delivered twice.
      RECOVER: if (!bus.alu_end) state_nxt = (bus.rsp_valid && !bus.rsp_ready) ? RESP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.cmd_op, bus.cmd_x, bus.cmd_y};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      tcnt            <= '0;
      end_prev        <= 1'b0;
      bus.alu_x       <= '0;
      bus.alu_y       <= '0;
      bus.alu_op      <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_data    <= '0;
      bus.rsp_op      <= '0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        {bus.alu_op, bus.alu_x, bus.alu_y} <= mem[rd_ptr];
      end
      count <= count + CW'(push) - CW'(pop);

      if (state == ISSUE) begin
        tcnt     <= '0;
        end_prev <= bus.alu_end;
      end
      if (state == WAIT) begin
        tcnt     <= tcnt + TW'(1);
        end_prev <= bus.alu_end;
      end

      // Completion wins over a timeout landing in the same cycle.
      if (done) begin
        bus.rsp_valid   <= 1'b1;
        bus.rsp_data    <= bus.alu_out;
        bus.rsp_op      <= bus.alu_op;
        bus.rsp_timeout <= 1'b0;
      end else if (expired) begin
        bus.rsp_valid   <= 1'b1;
        bus.rsp_data    <= 16'h0000;
        bus.rsp_op      <= bus.alu_op;
        bus.rsp_timeout <= 1'b1;
      end else if (rsp_fire) begin
        bus.rsp_valid   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_requester.sv
// tb/tb_alu_requester.sv - table-driven and scoreboard bench for alu_requester
module tb_alu_requester;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;
  localparam int M_NORMAL = 0;
  localparam int M_STALL  = 1;
  localparam int M_STUCK  = 2;

  logic clk = 1'b0;
  logic reset;
  alu_requester_if bus();

  alu_requester #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [2:0]  op;
    int          lat;
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs [10];
  logic [19:0] exp_q [$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_push = 0;
  int          n_rsp = 0;
  int          n_begin = 0;
  int          alu_mode = M_NORMAL;
  int          alu_lat = 1;
  bit          alu_hold = 0;
  bit          act = 0;
  bit          end_pulse = 0;
  int          cnt = 0;
  logic [15:0] alu_res = '0;
  bit          exp_to = 0;
  bit          use_ovr = 0;
  logic [15:0] exp_ovr = '0;

  function automatic logic [15:0] alu_f(input logic [7:0] x, input logic [7:0] y, input logic [2:0] op);
    case (op)
      3'd0:    alu_f = {8'h00, x} + {8'h00, y};
      3'd1:    alu_f = {8'h00, x} - {8'h00, y};
      3'd2:    alu_f = {8'h00, x} * {8'h00, y};
      3'd3:    alu_f = {8'h00, x & y};
      3'd4:    alu_f = {8'h00, x | y};
      3'd5:    alu_f = {8'h00, x ^ y};
      3'd6:    alu_f = {x, y};
      default: alu_f = {y, x};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act_v, exp_v);
    end
  endtask

  // One clock: observe handshakes before the edge, then advance the ALU model after it.
  task automatic step();
    logic [19:0] e;
    bit          begin_now;
    if (bus.cmd_valid && bus.cmd_ready) begin
      n_push++;
      exp_q.push_back({exp_to, bus.cmd_op,
                       exp_to ? 16'h0000 : (use_ovr ? exp_ovr : alu_f(bus.cmd_x, bus.cmd_y, bus.cmd_op))});
    end
    if (bus.rsp_valid && bus.rsp_ready) begin
      n_rsp++;
      chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rsp", {12'h0, bus.rsp_timeout, bus.rsp_op, bus.rsp_data}, {12'h0, e});
      end
    end
    begin_now = (bus.alu_begin === 1'b1);
    if (begin_now) begin
      n_begin++;
      alu_res = alu_f(bus.alu_x, bus.alu_y, bus.alu_op);
    end
    @(posedge clk);
    #1;
    if (end_pulse) begin
      bus.alu_end = 1'b0;
      end_pulse = 0;
    end
    if (begin_now) begin
      if (alu_mode == M_STUCK) begin
        bus.alu_out = alu_res;
        act = 0;
      end else begin
        bus.alu_end = 1'b0;
        act = (alu_mode == M_NORMAL);
        cnt = alu_lat;
      end
    end
    if (act) begin
      if (cnt == 0) begin
        bus.alu_end = 1'b1;
        bus.alu_out = alu_res;
        act = 0;
        end_pulse = !alu_hold;
      end else cnt--;
    end
  endtask

  task automatic push_cmd(input logic [7:0] x, input logic [7:0] y, input logic [2:0] op);
    int n = 0;
    int p0 = n_push;
    bus.cmd_x = x;
    bus.cmd_y = y;
    bus.cmd_op = op;
    bus.cmd_valid = 1'b1;
    while (n_push == p0 && n < 50) begin
      step();
      n++;
    end
    bus.cmd_valid = 1'b0;
    chk("cmd_accepted", n_push - p0, 1);
  endtask

  task automatic wait_rsp_valid(input string name, input int limit);
    int n = 0;
    while (!bus.rsp_valid && n < limit) begin
      step();
      n++;
    end
    chk(name, 32'(bus.rsp_valid), 32'd1);
  endtask

  task automatic wait_begin(input string name, input int limit);
    int n = 0;
    int b0 = n_begin;
    while (n_begin == b0 && n < limit) begin
      step();
      n++;
    end
    chk(name, n_begin - b0, 1);
  endtask

  task automatic drain(input string name, input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < limit) begin
      step();
      n++;
    end
    chk(name, 32'(exp_q.size() == 0 && !bus.busy), 32'd1);
  endtask

  initial begin
    int n;
    int b0;
    int p0;
    int r0;
    vecs[0] = '{x: 8'h05, y: 8'h03, op: 3'd0, lat: 4, exp: 16'h0008};
    vecs[1] = '{x: 8'hFF, y: 8'h01, op: 3'd0, lat: 0, exp: 16'h0100};
    vecs[2] = '{x: 8'h03, y: 8'h05, op: 3'd1, lat: 2, exp: 16'hFFFE};
    vecs[3] = '{x: 8'h10, y: 8'h10, op: 3'd2, lat: 5, exp: 16'h0100};
    vecs[4] = '{x: 8'hF0, y: 8'h3C, op: 3'd3, lat: 1, exp: 16'h0030};
    vecs[5] = '{x: 8'hF0, y: 8'h0F, op: 3'd4, lat: 3, exp: 16'h00FF};
    vecs[6] = '{x: 8'hAA, y: 8'hFF, op: 3'd5, lat: 0, exp: 16'h0055};
    vecs[7] = '{x: 8'h12, y: 8'h34, op: 3'd6, lat: 2, exp: 16'h1234};
    vecs[8] = '{x: 8'h12, y: 8'h34, op: 3'd7, lat: 1, exp: 16'h3412};
    vecs[9] = '{x: 8'hFF, y: 8'hFF, op: 3'd2, lat: 6, exp: 16'hFE01};

    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_x = '0;
    bus.cmd_y = '0;
    bus.cmd_op = '0;
    bus.alu_end = 1'b0;
    bus.alu_out = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_alu_begin", 32'(bus.alu_begin), 32'd0);
    chk("rst_alu_x", 32'(bus.alu_x), 32'd0);
    chk("rst_alu_y", 32'(bus.alu_y), 32'd0);
    chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("rst_rsp_op", 32'(bus.rsp_op), 32'd0);
    chk("rst_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);

    // Minimum latency: push to rsp_valid with an ALU that ends at once
    alu_lat = 0;
    b0 = n_begin;
    bus.cmd_x = 8'h05;
    bus.cmd_y = 8'h03;
    bus.cmd_op = 3'd0;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      step();
      n++;
    end
    chk("min_latency", n, 3);
    chk("min_lat_data", 32'(bus.rsp_data), 32'h0008);
    drain("min_lat_drain", 50);
    chk("min_lat_begins", n_begin - b0, 1);

    // Table of single commands
    for (int i = 0; i < 10; i++) begin
      alu_lat = vecs[i].lat;
      use_ovr = 1;
      exp_ovr = vecs[i].exp;
      b0 = n_begin;
      push_cmd(vecs[i].x, vecs[i].y, vecs[i].op);
      use_ovr = 0;
      drain("vec_drain", 300);
      chk("vec_begins", n_begin - b0, 1);
    end

    // FIFO fill while a response is held, then in-order drain
    alu_lat = 1;
    bus.rsp_ready = 1'b0;
    r0 = n_rsp;
    push_cmd(8'h21, 8'h02, 3'd2);
    wait_rsp_valid("hold_first_valid", 50);
    p0 = n_push;
    for (int i = 0; i <= DEPTH; i++) begin
      bus.cmd_x = 8'(i + 1);
      bus.cmd_y = 8'(8'h40 + i);
      bus.cmd_op = 3'(i);
      bus.cmd_valid = 1'b1;
      step();
    end
    bus.cmd_valid = 1'b0;
    chk("fifo_accepts", n_push - p0, DEPTH);
    chk("fifo_full_ready", 32'(bus.cmd_ready), 32'd0);
    b0 = n_begin;
    for (int i = 0; i < 10; i++) begin
      chk("rsp_hold_data", 32'(bus.rsp_data), 32'(alu_f(8'h21, 8'h02, 3'd2)));
      step();
    end
    chk("hold_no_begin", n_begin - b0, 0);
    chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
    bus.rsp_ready = 1'b1;
    drain("fifo_drain", 500);
    chk("fifo_rsp_count", n_rsp - r0, DEPTH + 1);

    // Timeout, with a second command waiting behind it
    bus.rsp_ready = 1'b0;
    alu_mode = M_STALL;
    exp_to = 1;
    bus.cmd_x = 8'h77;
    bus.cmd_y = 8'h11;
    bus.cmd_op = 3'd5;
    bus.cmd_valid = 1'b1;
    step();
    exp_to = 0;
    bus.cmd_x = 8'h09;
    bus.cmd_y = 8'h04;
    bus.cmd_op = 3'd1;
    step();
    bus.cmd_valid = 1'b0;
    wait_begin("to_begin", 20);
    alu_mode = M_NORMAL;
    alu_lat = 2;
    n = 1;
    while (!bus.rsp_valid && n < 200) begin
      step();
      n++;
    end
    chk("to_cycles", n, TIMEOUT + 1);
    chk("to_flag", 32'(bus.rsp_timeout), 32'd1);
    chk("to_data", 32'(bus.rsp_data), 32'd0);
    b0 = n_begin;
    repeat (5) step();
    chk("to_no_second_begin", n_begin - b0, 0);
    bus.rsp_ready = 1'b1;
    drain("to_drain", 100);
    chk("to_second_begin", n_begin - b0, 1);

    // alu_end held high across two commands
    alu_hold = 1;
    alu_lat = 1;
    push_cmd(8'h31, 8'h22, 3'd0);
    drain("stale_first_drain", 100);
    chk("stale_end_high", 32'(bus.alu_end), 32'd1);
    alu_mode = M_STUCK;
    exp_to = 1;
    push_cmd(8'h44, 8'h55, 3'd4);
    exp_to = 0;
    wait_rsp_valid("stale_valid", 200);
    chk("stale_is_timeout", 32'(bus.rsp_timeout), 32'd1);
    bus.alu_end = 1'b0;
    alu_hold = 0;
    drain("stale_drain", 50);
    bus.alu_end = 1'b1;
    alu_mode = M_NORMAL;
    alu_lat = 2;
    b0 = n_begin;
    push_cmd(8'h66, 8'h03, 3'd2);
    drain("fresh_edge_drain", 100);
    chk("fresh_edge_begins", n_begin - b0, 1);

    // Reset during WAIT, then a late alu_end
    alu_mode = M_STALL;
    push_cmd(8'h0A, 8'h0B, 3'd0);
    wait_begin("rst_wait_begin", 20);
    repeat (3) step();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    exp_q.delete();
    r0 = n_rsp;
    b0 = n_begin;
    bus.alu_end = 1'b1;
    step();
    bus.alu_end = 1'b0;
    repeat (5) step();
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("mid_rst_no_rsp", n_rsp - r0, 0);
    chk("mid_rst_no_begin", n_begin - b0, 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
